// File: rtl/localbus_arbiter_pkg.sv
// Shared types and defaults for the two-master local bus arbiter.
// Owner-state encoding, hold-counter width and parameter defaults live here.
package localbus_arbiter_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_W       = 8;

    typedef enum logic [1:0] {
        OWN_FREE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    function automatic owner_e owner_of(input logic id);
        return id ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/localbus_arbiter_if.sv
// Master-side request/response signals plus the localbus slave port, bundled.
interface localbus_arbiter_if #(
    parameter int XLEN = 32
);
    logic            m0_req,    m1_req;
    logic            m0_lock,   m1_lock;
    logic [XLEN-1:0] m0_addr,   m1_addr;
    logic [XLEN-1:0] m0_wdata,  m1_wdata;
    logic [3:0]      m0_we,     m1_we;
    logic            m0_gnt,    m1_gnt;
    logic            m0_rvalid, m1_rvalid;
    logic [XLEN-1:0] m0_rdata,  m1_rdata;

    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_qin;
    logic [3:0]      bus_we;
    logic [XLEN-1:0] bus_qout;

    modport slave (
        input  m0_req, m1_req, m0_lock, m1_lock,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output bus_addr, bus_qin, bus_we,
        input  bus_qout
    );

    modport master (
        output m0_req, m1_req, m0_lock, m1_lock,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  bus_addr, bus_qin, bus_we,
        output bus_qout
    );

endinterface

// File: rtl/localbus_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the master not granted last wins.
module localbus_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    // NOTE: gnt gets its default before any branch so no path infers a latch.
    always_comb begin
        gnt = req;
        if (&req) gnt = last ? 2'b01 : 2'b10;
    end

    // Reset to 1 so master 0 wins the first tie.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end

endmodule

// File: rtl/localbus_arbiter.sv
// Two-master round-robin arbiter with lock and hold limit in front of localbus.
// Grants are combinational; read data returns one cycle after the grant.
module localbus_arbiter
    import localbus_arbiter_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input logic               clk,
    input logic               rst_n,
    localbus_arbiter_if.slave lb
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    owner_e            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              own_id, own_lock, other_req;
    logic              hold_expired, arb_open;
    logic [1:0]        req_vec, gnt_vec;
    logic              rd_pend, rd_id;
    logic              m0_rv, m1_rv;
    logic [XLEN-1:0]   sel_addr, sel_wdata;
    logic [3:0]        sel_we;

    assign own_id       = (state == OWN_M1);
    assign own_lock     = own_id ? lb.m1_lock : lb.m0_lock;
    assign other_req    = own_id ? lb.m0_req  : lb.m1_req;
    assign hold_expired = (state != OWN_FREE) && (hold_cnt == HOLD_LIMIT);
    assign arb_open     = ((state != OWN_M0) && (state != OWN_M1)) || hold_expired;

    // While owned, only the owner may request. On hold expiry the picker's
    // last already equals the owner, so a requesting other master wins.
    always_comb begin
        req_vec = {lb.m1_req, lb.m0_req};
        if (!arb_open) req_vec = own_id ? {lb.m1_req, 1'b0} : {1'b0, lb.m0_req};
    end

    localbus_arbiter_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .gnt   (gnt_vec)
    );

    assign lb.m0_gnt = gnt_vec[0];
    assign lb.m1_gnt = gnt_vec[1];

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (arb_open) begin
            state_nxt = OWN_FREE;
            if ((gnt_vec[0] && lb.m0_lock) || (gnt_vec[1] && lb.m1_lock)) begin
                state_nxt    = owner_of(gnt_vec[1]);
                hold_cnt_nxt = '0;
            end
        end else if (!own_lock) begin
            state_nxt = OWN_FREE;
        end else if (other_req) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OWN_FREE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Idle bus shows master 0's address/data with no write strobe.
    always_comb begin
        sel_addr  = lb.m0_addr;
        sel_wdata = lb.m0_wdata;
        sel_we    = 4'b0000;
        if (gnt_vec[1]) begin
            sel_addr  = lb.m1_addr;
            sel_wdata = lb.m1_wdata;
            sel_we    = lb.m1_we;
        end else if (gnt_vec[0]) begin
            sel_we = lb.m0_we;
        end
    end

    assign lb.bus_addr = sel_addr;
    assign lb.bus_qin  = sel_wdata;
    assign lb.bus_we   = sel_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_id   <= 1'b0;
        end else begin
            rd_pend <= (|gnt_vec) && (sel_we == 4'b0000);
            rd_id   <= gnt_vec[1];
        end
    end

    assign m0_rv        = rd_pend && !rd_id;
    assign m1_rv        = rd_pend && rd_id;
    assign lb.m0_rvalid = m0_rv;
    assign lb.m1_rvalid = m1_rv;
    assign lb.m0_rdata  = m0_rv ? lb.bus_qout : '0;
    assign lb.m1_rdata  = m1_rv ? lb.bus_qout : '0;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Bench for localbus_arbiter: scenario tasks plus a read-return scoreboard
// against a one-cycle registered RAM standing in for localbus.
module tb_localbus_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_HOLD = 4;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    rd_exp_t     sb[$];
    rd_exp_t     mon_exp;
    logic [1:0]  mon_v;
    logic [31:0] mon_d, mon_o;

    bit [31:0] ram_data[256];
    bit        ram_written[256];

    localbus_arbiter_if #(.XLEN(XLEN)) lb ();

    localbus_arbiter #(.XLEN(XLEN), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb    (lb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4)  return 32'h1234_5678;
        if (idx == 16) return 32'h0000_0000;
        return {8'hC0, 8'(idx), 8'(~idx), 8'(idx ^ 8'h5A)};
    endfunction

    function automatic logic [31:0] cur_word(input int idx);
        return ram_written[idx] ? ram_data[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Slave model: byte-enabled write, registered read, one cycle latency.
    always @(posedge clk) begin
        if (|lb.bus_we) begin
            ram_data[lb.bus_addr[9:2]]    <= merge(cur_word(int'(lb.bus_addr[9:2])), lb.bus_qin, lb.bus_we);
            ram_written[lb.bus_addr[9:2]] <= 1'b1;
        end
        lb.bus_qout <= cur_word(int'(lb.bus_addr[9:2]));
        cyc         <= cyc + 1;
    end

    // Read-return scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL read_missing: no rvalid for m%0d at cycle %0d, required at cycle %0d",
                         sb[0].id, cyc, sb[0].due);
                void'(sb.pop_front());
            end
            checks++;
            if (lb.m0_rvalid !== 1'b1 && lb.m1_rvalid !== 1'b1) begin
                if (lb.m0_rdata !== '0 || lb.m1_rdata !== '0) begin
                    errors++;
                    $display("FAIL idle_rdata: m0_rdata %h m1_rdata %h, required 0", lb.m0_rdata, lb.m1_rdata);
                end
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: rvalid %b%b at cycle %0d, required none",
                         lb.m1_rvalid, lb.m0_rvalid, cyc);
            end else begin
                mon_exp = sb.pop_front();
                mon_v   = {lb.m1_rvalid, lb.m0_rvalid};
                mon_d   = mon_exp.id ? lb.m1_rdata : lb.m0_rdata;
                mon_o   = mon_exp.id ? lb.m0_rdata : lb.m1_rdata;
                if (mon_v !== (mon_exp.id ? 2'b10 : 2'b01) || mon_d !== mon_exp.data ||
                    mon_o !== '0 || cyc != mon_exp.due) begin
                    errors++;
                    $display("FAIL read_return: rvalid %b data %h other %h cycle %0d, required rvalid %b data %h other 0 cycle %0d",
                             mon_v, mon_d, mon_o, cyc, (mon_exp.id ? 2'b10 : 2'b01), mon_exp.data, mon_exp.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit id, input bit req, input bit lock, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] we);
        if (id) begin
            lb.m1_req = req; lb.m1_lock = lock; lb.m1_addr = addr; lb.m1_wdata = data; lb.m1_we = we;
        end else begin
            lb.m0_req = req; lb.m0_lock = lock; lb.m0_addr = addr; lb.m0_wdata = data; lb.m0_we = we;
        end
    endtask

    task automatic drive_idle();
        set_m(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        set_m(1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic expect_read(input bit id, input logic [31:0] data);
        sb.push_back('{id, data, cyc + 1});
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: %b, required 00", {lb.m1_gnt, lb.m0_gnt});
        end
        checks++;
        if ({lb.m1_rvalid, lb.m0_rvalid} !== 2'b00 || lb.m0_rdata !== '0 || lb.m1_rdata !== '0) begin
            errors++; $display("FAIL reset_read: rvalid %b rdata %h/%h, required 00 and 0",
                               {lb.m1_rvalid, lb.m0_rvalid}, lb.m0_rdata, lb.m1_rdata);
        end
        checks++;
        if (lb.bus_we !== 4'h0 || lb.bus_addr !== '0 || lb.bus_qin !== '0) begin
            errors++; $display("FAIL reset_bus: we %h addr %h qin %h, required 0",
                               lb.bus_we, lb.bus_addr, lb.bus_qin);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_master();
        set_m(1'b0, 1'b1, 1'b0, 32'h10, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01 || lb.bus_addr !== 32'h10 || lb.bus_we !== 4'h0) begin
            errors++; $display("FAIL single_gnt: gnt %b addr %h we %h, required 01 00000010 0",
                               {lb.m1_gnt, lb.m0_gnt}, lb.bus_addr, lb.bus_we);
        end
        expect_read(1'b0, 32'h1234_5678);
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (lb.m0_rvalid !== 1'b1 || lb.m0_rdata !== 32'h1234_5678 || lb.m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL single_rvalid: m0 %b %h m1 %b, required 1 12345678 0",
                               lb.m0_rvalid, lb.m0_rdata, lb.m1_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] a0, a1;
        bit          w;
        apply_reset();
        a0 = 32'h100;
        a1 = 32'h200;
        w  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_m(1'b0, 1'b1, 1'b0, a0, '0, 4'h0);
            set_m(1'b1, 1'b1, 1'b0, a1, '0, 4'h0);
            @(negedge clk);
            checks++;
            if ({lb.m1_gnt, lb.m0_gnt} !== (w ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_gnt[%0d]: %b, required %b",
                                   i, {lb.m1_gnt, lb.m0_gnt}, (w ? 2'b10 : 2'b01));
            end
            checks++;
            if (lb.bus_addr !== (w ? a1 : a0)) begin
                errors++; $display("FAIL contention_addr[%0d]: %h, required %h", i, lb.bus_addr, (w ? a1 : a0));
            end
            expect_read(w, init_word(int'((w ? a1 : a0) >> 2)));
            if (w) a1 += 32'h4;
            else   a0 += 32'h4;
            w = ~w;
            tick();
        end
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_lock_ignored();
        apply_reset();
        set_m(1'b0, 1'b1, 1'b0, 32'h10, '0, 4'h0);
        set_m(1'b1, 1'b1, 1'b1, 32'h20, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_ignored_tie: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b0, init_word(4));
        tick();
        set_m(1'b0, 1'b1, 1'b0, 32'h14, '0, 4'h0);
        set_m(1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_ignored_next: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b0, init_word(5));
        tick();
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_lock();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            set_m(1'b1, 1'b1, (k < 2), 32'h300 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'hF);
            if (k > 0) set_m(1'b0, 1'b1, 1'b0, 32'h10, '0, 4'h0);
            @(negedge clk);
            checks++;
            if ({lb.m1_gnt, lb.m0_gnt} !== 2'b10 || lb.bus_we !== 4'hF ||
                lb.bus_addr !== 32'h300 + 32'(4 * k) || lb.bus_qin !== 32'h1111_1111 * 32'(k + 1)) begin
                errors++; $display("FAIL lock_write[%0d]: gnt %b we %h addr %h qin %h, required 10 f %h %h",
                                   k, {lb.m1_gnt, lb.m0_gnt}, lb.bus_we, lb.bus_addr, lb.bus_qin,
                                   32'h300 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1));
            end
            tick();
        end
        set_m(1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_release: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b0, 32'h1234_5678);
        tick();
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_hold_limit();
        apply_reset();
        set_m(1'b0, 1'b1, 1'b1, 32'h3C0, 32'hD0D0_0000, 4'hF);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL hold_enter: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        tick();
        for (int k = 1; k <= MAX_HOLD + 1; k++) begin
            set_m(1'b1, 1'b1, 1'b0, 32'h10, '0, 4'h0);
            @(negedge clk);
            checks++;
            if ({lb.m1_gnt, lb.m0_gnt} !== ((k <= MAX_HOLD) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL hold_cycle[%0d]: %b, required %b",
                                   k, {lb.m1_gnt, lb.m0_gnt}, ((k <= MAX_HOLD) ? 2'b01 : 2'b10));
            end
            if (k > MAX_HOLD) expect_read(1'b1, 32'h1234_5678);
            tick();
        end
        set_m(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        set_m(1'b1, 1'b1, 1'b0, 32'h14, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b10) begin
            errors++; $display("FAIL hold_free: %b, required 10", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b1, init_word(5));
        tick();
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_m(1'b0, 1'b1, 1'b1, 32'h10, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL midrst_gnt: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        #1;
        rst_n = 1'b0;
        drive_idle();
        #1;
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b00 || lb.bus_we !== 4'h0 || lb.bus_addr !== '0 || lb.bus_qin !== '0) begin
            errors++; $display("FAIL midrst_outputs: gnt %b we %h addr %h qin %h, required 00 0 0 0",
                               {lb.m1_gnt, lb.m0_gnt}, lb.bus_we, lb.bus_addr, lb.bus_qin);
        end
        tick();
        checks++;
        if ({lb.m1_rvalid, lb.m0_rvalid} !== 2'b00 || lb.m0_rdata !== '0 || lb.m1_rdata !== '0) begin
            errors++; $display("FAIL midrst_rvalid: %b rdata %h/%h, required 00 and 0",
                               {lb.m1_rvalid, lb.m0_rvalid}, lb.m0_rdata, lb.m1_rdata);
        end
        rst_n = 1'b1;
        set_m(1'b0, 1'b1, 1'b0, 32'h18, '0, 4'h0);
        set_m(1'b1, 1'b1, 1'b0, 32'h1C, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL midrst_tie: %b, required 01", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b0, init_word(6));
        tick();
        set_m(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        checks++;
        if ({lb.m1_gnt, lb.m0_gnt} !== 2'b10) begin
            errors++; $display("FAIL midrst_m1: %b, required 10", {lb.m1_gnt, lb.m0_gnt});
        end
        expect_read(1'b1, init_word(7));
        tick();
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_byte_write();
        set_m(1'b1, 1'b1, 1'b0, 32'h40, 32'hAABB_CCDD, 4'b0010);
        @(negedge clk);
        checks++;
        if (lb.m1_gnt !== 1'b1 || lb.bus_we !== 4'b0010 || lb.bus_addr !== 32'h40 || lb.bus_qin !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL byte_write: gnt %b we %b addr %h qin %h, required 1 0010 00000040 aabbccdd",
                               lb.m1_gnt, lb.bus_we, lb.bus_addr, lb.bus_qin);
        end
        tick();
        set_m(1'b1, 1'b1, 1'b0, 32'h40, '0, 4'h0);
        @(negedge clk);
        checks++;
        if (lb.m1_gnt !== 1'b1 || lb.bus_we !== 4'h0) begin
            errors++; $display("FAIL byte_readback_gnt: gnt %b we %h, required 1 0", lb.m1_gnt, lb.bus_we);
        end
        expect_read(1'b1, 32'h0000_CC00);
        tick();
        drive_idle();
        @(negedge clk);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_contention();
        test_lock_ignored();
        test_lock();
        test_hold_limit();
        test_reset_mid_read();
        test_byte_write();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/localbus_arbiter.md
# localbus_arbiter

Two-master arbiter placed in front of the `localbus` slave port, sharing the local bus between the CPU data port (master 0) and a second bus master such as a DMA or VRAM blitter (master 1). It grants one master per cycle using round-robin priority and steers that master's address, write data and byte enables onto the bus. It returns the synchronous read data one cycle later, tagged to the master that issued the read. A lock input lets a master hold the bus for atomic sequences, capped by a hold-cycle limit.

## Interface
- `XLEN`, 32: data/address width, taken from `core_general.vh`.
- `MAX_HOLD`, 16: maximum consecutive cycles a locked master keeps the bus while the other master is requesting. Range 1..255.
- `clk` in 1: global clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain; the polarity and synchronicity are fixed.
- `m0_req`, `m1_req` in 1: access request.
- `m0_lock`, `m1_lock` in 1: keep ownership after the current access.
- `m0_addr`, `m1_addr` in XLEN: byte address.
- `m0_wdata`, `m1_wdata` in XLEN: write data.
- `m0_we`, `m1_we` in 4: byte write enables. `4'b0000` means a read.
- `m0_gnt`, `m1_gnt` out 1: access accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1: read data valid for that master.
- `m0_rdata`, `m1_rdata` out XLEN: read data.
- `bus_addr` out XLEN: to `localbus` `addr`.
- `bus_qin` out XLEN: to `localbus` `qin`.
- `bus_we` out 4: to `localbus` `we`.
- `bus_qout` in XLEN: from `localbus` `qout`.

## Operation
- **Owner state:** FREE, OWN0, OWN1. Reset state is FREE. The registered `last` (last master granted) resets to 1, so master 0 wins the first tie.
- **FREE:**
  - A single requester is granted.
  - If both request, the master that is not `last` wins.
  - If the winner has `lock` high in that cycle, go to OWNx.
- **OWNx:**
  - Master x has absolute priority.
  - The other master is not granted, even when x is idle.
  - Leave to FREE when x drops `lock`. The cycle in which `lock` falls may still carry a granted access.
- **Hold counter:**
  - 8 bits. Cleared on entry to OWNx.
  - Increments each OWNx cycle in which the other master requests.
  - When it reaches `MAX_HOLD`, go to FREE, set `last`=x, and grant the other master in that same cycle if it requests.
- **Grant:**
  - `mX_gnt` = winner and `mX_req`, combinational in the request cycle.
  - At most one `gnt` is high per cycle.
  - The master holds `req`/`addr`/`wdata`/`we` stable until it sees `gnt`.
  - `last` updates on every grant.
- **Bus mux:**
  - `bus_addr`/`bus_qin`/`bus_we` come from the granted master.
  - With no grant: `bus_we`=0, and `bus_addr`/`bus_qin` hold the last master-0 values. This is harmless because reads have no side effects on the bus.
- **Read return:**
  - A grant with `we`=0 sets the registered `rd_pend`/`rd_id`.
  - On the next cycle, `mX_rvalid` is 1 for `rd_id` and `mX_rdata` = `bus_qout`.
  - The non-target `rdata` is 0.
- **Writes:** complete in the grant cycle and produce no `rvalid`.
- **Back-to-back:** accesses are allowed every cycle. A new grant may overlap the previous read's data return.

## Timing
- Grant latency: 0 cycles (same cycle as `req`) when not blocked.
- Read latency: `rvalid` exactly 1 cycle after `gnt`, matching the one-cycle registered read of RAM/VRAM/GPIO/Timer.
- Reset values: all `gnt` 0, all `rvalid` 0, all `rdata` 0, `bus_we` 0, `bus_addr` 0, `bus_qin` 0, state FREE, counter 0, `rd_pend` 0.
- Reset asserted mid-operation:
  - All registers clear asynchronously.
  - The pending `rvalid` is dropped.
  - The lock is released.
- Lock asserted by a master that was not granted in that cycle has no effect.

## Structure
- Owner-state encoding (FREE/OWN0/OWN1) and `MAX_HOLD` default go in a shared `localbus_pkg.vh` alongside the bus base addresses.
- XLEN comes from `core_general.vh`.
- Natural sub-module: `rr_arb2`, a two-input round-robin picker with `last` register. The rest is the owner FSM, hold counter and read-return register.
- `localbus` instantiates unchanged behind `bus_*`.

## Test plan
- **Single master:**
  - Stimulus: m0 reads 0x0000_0010 with RAM holding 0x1234_5678.
  - Required: `m0_gnt`=1 in cycle T; `m0_rvalid`=1 and `m0_rdata`=0x1234_5678 at T+1; `m1_rvalid`=0 throughout.
- **Contention:**
  - Stimulus: both masters request every cycle, no lock, from reset.
  - Required: grants alternate m0, m1, m0, m1…; `bus_addr` tracks the winner; each `rvalid` goes to the correct master.
- **Lock:**
  - Stimulus: m1 locked for 3 writes while m0 requests.
  - Required: m0 is blocked; the 3 writes land with `bus_we`=4'b1111; m0 is granted the cycle after m1 drops `lock`.
- **Hold limit:**
  - Stimulus: `MAX_HOLD`=4; m0 keeps `lock` high continuously; m1 requests.
  - Required: m1 is granted on the 5th contending cycle; the state returns to FREE.
- **Reset mid-read:**
  - Stimulus: assert `rst_n`=0 between `gnt` and `rvalid`.
  - Required: no `rvalid` is produced; outputs return to reset values immediately; the first post-reset tie goes to m0.
- **Byte write:**
  - Stimulus: m1 writes `we`=4'b0010, data 0xAABB_CCDD to a RAM word holding 0, then m1 reads the same word.
  - Required: read returns 0x0000_CC00.
